// File: rtl/packet_arbiter.sv
// packet_arbiter: round-robin arbiter merging INPUTS two-phase packet sources
// onto one two-phase output channel. A granted source keeps the channel for
// exactly FLITS flits before arbitration resumes from the next index.
//
// Optional feature macro: PACKET_ARBITER_HEAD_CHECK_EN
//   defined   -> only sources presenting a head flit (bit SIZE-1 set) are
//                eligible; headless pending sources in IDLE and head flits
//                seen mid-packet raise the sticky err flag.
//   undefined -> every pending source is eligible, err is held at 0.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous active-low reset
//   in_req    per-source toggle request
//   in_data   source i flit at [i*SIZE +: SIZE]
//   in_ack    per-source toggle acknowledge
//   out_req   toggle request to downstream
//   out_data  flit presented downstream
//   out_ack   toggle acknowledge from downstream
//   grant     one-hot channel owner, zero when idle
//   err       sticky protocol error
module packet_arbiter #(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned SIZE   = 8,
    parameter int unsigned FLITS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUTS-1:0]      in_req,
    input  logic [INPUTS*SIZE-1:0] in_data,
    output logic [INPUTS-1:0]      in_ack,
    output logic                   out_req,
    output logic [SIZE-1:0]        out_data,
    input  logic                   out_ack,
    output logic [INPUTS-1:0]      grant,
    output logic                   err
);
    localparam int unsigned IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [INPUTS-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]     r_idx, w_idx_nxt;
    logic [IW-1:0]     r_last, w_last_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [INPUTS-1:0] r_in_ack, w_in_ack_nxt;
    logic              r_out_req, w_out_req_nxt;
    logic [SIZE-1:0]   r_out_data, w_out_data_nxt;
    logic              r_err, w_err_nxt;

    logic [INPUTS-1:0] w_pend;
    logic [INPUTS-1:0] w_elig;
    logic              w_sel_found;
    logic [IW-1:0]     w_sel_idx;
    logic [SIZE-1:0]   w_gdata;
    logic              w_gpend;
`ifdef PACKET_ARBITER_HEAD_CHECK_EN
    logic [INPUTS-1:0] w_head;
`endif

    // Pending sources and the subset allowed to win arbitration
    always_comb begin
        w_pend = in_req ^ r_in_ack;
`ifdef PACKET_ARBITER_HEAD_CHECK_EN
        for (int i = 0; i < int'(INPUTS); i++) begin
            w_head[i] = in_data[i*SIZE + SIZE - 1];
        end
        w_elig = w_pend & w_head;
`else
        w_elig = w_pend;
`endif
    end

    // Round-robin pick: first eligible index after the previous owner
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 1; k <= int'(INPUTS); k++) begin
            if (!w_sel_found && w_elig[IW'((int'(r_last) + k) % int'(INPUTS))]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'((int'(r_last) + k) % int'(INPUTS));
            end
        end
    end

    // Flit and pending status of the current owner
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < int'(INPUTS); i++) begin
            if (r_idx == IW'(i)) begin
                w_gdata = in_data[i*SIZE +: SIZE];
            end
        end
        w_gpend = |(w_pend & r_grant);
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_idx_nxt      = r_idx;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_in_ack_nxt   = r_in_ack;
        w_out_req_nxt  = r_out_req;
        w_out_data_nxt = r_out_data;
        w_err_nxt      = r_err;
        w_cnt_inc      = r_cnt + CW'(1);

        case (r_state)
            IDLE: begin
`ifdef PACKET_ARBITER_HEAD_CHECK_EN
                if (|(w_pend & ~w_head)) begin
                    w_err_nxt = 1'b1;
                end
`endif
                if (w_sel_found) begin
                    w_grant_nxt = INPUTS'(1) << w_sel_idx;
                    w_idx_nxt   = w_sel_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_gpend) begin
                    w_out_data_nxt = w_gdata;
                    w_out_req_nxt  = ~r_out_req;
                    w_state_nxt    = WAIT;
`ifdef PACKET_ARBITER_HEAD_CHECK_EN
                    // Head marker inside a packet is flagged but still forwarded
                    if ((r_cnt != '0) && w_gdata[SIZE-1]) begin
                        w_err_nxt = 1'b1;
                    end
`endif
                end
            end
            WAIT: begin
                if (out_ack == r_out_req) begin
                    w_in_ack_nxt = r_in_ack ^ r_grant;
                    w_cnt_nxt    = w_cnt_inc;
                    if (w_cnt_inc == CW'(FLITS)) begin
                        w_last_nxt  = r_idx;
                        w_grant_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = SEND;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_last     <= IW'(INPUTS - 1);
            r_cnt      <= '0;
            r_in_ack   <= '0;
            r_out_req  <= 1'b0;
            r_out_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_idx      <= w_idx_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ack   <= w_in_ack_nxt;
            r_out_req  <= w_out_req_nxt;
            r_out_data <= w_out_data_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign in_ack   = r_in_ack;
    assign out_req  = r_out_req;
    assign out_data = r_out_data;
    assign grant    = r_grant;
    assign err      = r_err;

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 SHALL have parameter INPUTS, default 4, number of packet sources sharing one output channel (2..8).
REQ-002 SHALL have parameter SIZE, default 8, flit width in bits; bit SIZE-1 is the head marker.
REQ-003 SHALL have parameter FLITS, default 8, flits per packet (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_req  input  INPUTS  per-source two-phase (toggle) request.
REQ-007 SHALL have port in_data  input  INPUTS*SIZE  source i flit at bits [i*SIZE +: SIZE].
REQ-008 SHALL have port in_ack  output  INPUTS  per-source two-phase acknowledge.
REQ-009 SHALL have port out_req  output  1  two-phase request to downstream.
REQ-010 SHALL have port out_data  output  SIZE  flit presented downstream.
REQ-011 SHALL have port out_ack  input  1  two-phase acknowledge from downstream.
REQ-012 SHALL have port grant  output  INPUTS  one-hot owner of the channel, zero when idle.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 Source i SHALL be pending when in_req[i] != in_ack[i]; the output channel SHALL be complete when out_ack == out_req.
REQ-015 FSM SHALL have states IDLE, SEND, WAIT; encoding is free.
REQ-016 IDLE: if any source is eligible, SHALL select the first eligible index scanning from last+1 modulo INPUTS (round-robin), set grant one-hot, clear flit count, go SEND; else stay IDLE with grant=0.
REQ-017 SEND: if granted source pending, SHALL latch its flit into out_data, toggle out_req, go WAIT; else stay SEND.
REQ-018 WAIT: when out_ack == out_req, SHALL toggle in_ack[grant], increment flit count; if count reaches FLITS, set last=grant, clear grant, go IDLE; else go SEND.
REQ-019 Grant SHALL be locked for exactly FLITS flits; other sources' requests SHALL be ignored until release.
REQ-020 Latency: pending source in IDLE at edge t -> grant at t+1 -> out_req toggle at t+2; out_ack match seen at edge u -> in_ack toggle at u+1.
REQ-021 At most one in_ack bit SHALL toggle per cycle; out_req SHALL never toggle while the channel is incomplete.
REQ-022 out_data SHALL hold stable from out_req toggle until the next SEND latch.
REQ-023 Flit counter SHALL be 8 bits; FLITS=1 SHALL release after the first flit.
REQ-024 Simultaneous in_req toggles SHALL be resolved by REQ-016 only; no request SHALL be lost (pending persists until acked).

Reset
REQ-025 On reset low, SHALL immediately set state IDLE, in_ack=0, out_req=0, out_data=0, grant=0, err=0, flit count=0, last=INPUTS-1 (source 0 wins first).
REQ-026 Reset mid-packet SHALL abandon the packet with no further toggles; sources and downstream are reset together.

Configuration
REQ-027 Macro PACKET_ARBITER_HEAD_CHECK_EN: when defined, a source is eligible in IDLE only if pending with data bit SIZE-1 = 1; a pending source with bit SIZE-1 = 0 while IDLE SHALL set err (sticky until reset) and is skipped; a flit with bit SIZE-1 = 1 latched in SEND at count != 0 SHALL set err but still be forwarded.
REQ-028 When undefined, every pending source SHALL be eligible, no head checks are made, err SHALL be constant 0.

Verification (INPUTS=4, SIZE=8, FLITS=4, downstream acks 2 cycles after each out_req toggle)
REQ-029 Source 2 sends one packet 0x81,0x02,0x03,0x04 -> out_data sequence identical, grant=4'b0100 for the packet, in_ack[2] toggles 4 times, then grant=0.
REQ-030 Sources 0 and 3 toggle in_req in the same cycle after reset -> source 0 packet (4 flits) fully forwarded before any source 3 flit; no interleaving.
REQ-031 All four sources request continuously, 2 packets each -> grant order 0,1,2,3,0,1,2,3; 32 flits forwarded, none dropped or duplicated.
REQ-032 Reset asserted after flit 2 of a packet from source 1 -> outputs zero same cycle; after release a new packet from source 1 is forwarded from its head flit.
REQ-033 With PACKET_ARBITER_HEAD_CHECK_EN, source 1 pending with flit 0x05 in IDLE -> err=1, no grant to source 1; without the macro -> grant=4'b0010 and err stays 0.
REQ-034 Downstream holds out_ack for 10 cycles -> out_req and out_data stable, no in_ack toggles during the stall.
